// File: rtl/foreground_segmentation.sv
// Foreground segmentation: thresholds |image - background| into a binary mask
// stream and reports a per-frame foreground pixel count with saturation flag.
module foreground_segmentation #(
  parameter int COUNT_W = 22
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         in_image,
  input  logic [7:0]         in_background,
  input  logic               in_de,
  input  logic               in_hsync,
  input  logic               in_vsync,
  input  logic [7:0]         threshold,
  input  logic               enable,
  output logic [7:0]         out_mask,
  output logic               out_de,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic [COUNT_W-1:0] fg_count,
  output logic               fg_count_valid,
  output logic               fg_overflow
);

  typedef enum logic {WAIT_FRAME, COUNT} state_t;

  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  state_t             state_q, state_d;
  logic [7:0]         img_s1_q, img_s1_d, bg_s1_q, bg_s1_d;
  logic               de_s1_q, de_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic [7:0]         diff_s2_q, diff_s2_d;
  logic               de_s2_q, de_s2_d, hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;
  logic [7:0]         mask_s3_q, mask_s3_d;
  logic               de_s3_q, de_s3_d, hs_s3_q, hs_s3_d, vs_s3_q, vs_s3_d;
  logic [7:0]         thr_l_q, thr_l_d;
  logic               en_l_q, en_l_d;
  logic [COUNT_W-1:0] cnt_q, cnt_d, fg_count_q, fg_count_d;
  logic               sat_q, sat_d, fg_ovf_q, fg_ovf_d, fg_valid_q, fg_valid_d;

  logic [8:0]         sub;
  logic               frame_edge, fg_hit, sat_now;
  logic [COUNT_W-1:0] cnt_inc;

  always_comb begin
    img_s1_d = in_image;
    bg_s1_d  = in_background;
    de_s1_d  = in_de;
    hs_s1_d  = in_hsync;
    vs_s1_d  = in_vsync;

    sub       = {1'b0, img_s1_q} - {1'b0, bg_s1_q};
    diff_s2_d = sub[8] ? (~sub[7:0] + 8'd1) : sub[7:0];
    de_s2_d   = de_s1_q;
    hs_s2_d   = hs_s1_q;
    vs_s2_d   = vs_s1_q;

    // The pixel sitting in S2 on the frame edge still belongs to the old frame,
    // so it is judged with the old latched settings and counted before the close.
    frame_edge = vs_s2_q && !vs_s3_q;
    fg_hit     = de_s2_q && en_l_q && (diff_s2_q > thr_l_q);
    mask_s3_d  = fg_hit ? 8'd255 : 8'd0;
    de_s3_d    = de_s2_q;
    hs_s3_d    = hs_s2_q;
    vs_s3_d    = vs_s2_q;

    thr_l_d = frame_edge ? threshold : thr_l_q;
    en_l_d  = frame_edge ? enable : en_l_q;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    fg_count_d = fg_count_q;
    fg_ovf_d   = fg_ovf_q;
    fg_valid_d = 1'b0;

    cnt_inc = (fg_hit && (cnt_q != CNT_MAX)) ? cnt_q + COUNT_W'(1) : cnt_q;
    sat_now = sat_q || (fg_hit && (cnt_q == CNT_MAX));

    case (state_q)
      WAIT_FRAME: begin
        cnt_d = '0;
        sat_d = 1'b0;
        if (frame_edge) state_d = COUNT;
      end
      COUNT: begin
        cnt_d = cnt_inc;
        sat_d = sat_now;
        if (frame_edge) begin
          fg_count_d = cnt_inc;
          fg_ovf_d   = sat_now;
          fg_valid_d = 1'b1;
          cnt_d      = '0;
          sat_d      = 1'b0;
        end
      end
      default: state_d = WAIT_FRAME;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= WAIT_FRAME;
      img_s1_q   <= '0;
      bg_s1_q    <= '0;
      de_s1_q    <= 1'b0;
      hs_s1_q    <= 1'b0;
      vs_s1_q    <= 1'b0;
      diff_s2_q  <= '0;
      de_s2_q    <= 1'b0;
      hs_s2_q    <= 1'b0;
      vs_s2_q    <= 1'b0;
      mask_s3_q  <= '0;
      de_s3_q    <= 1'b0;
      hs_s3_q    <= 1'b0;
      vs_s3_q    <= 1'b0;
      thr_l_q    <= '0;
      en_l_q     <= 1'b0;
      cnt_q      <= '0;
      sat_q      <= 1'b0;
      fg_count_q <= '0;
      fg_ovf_q   <= 1'b0;
      fg_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      img_s1_q   <= img_s1_d;
      bg_s1_q    <= bg_s1_d;
      de_s1_q    <= de_s1_d;
      hs_s1_q    <= hs_s1_d;
      vs_s1_q    <= vs_s1_d;
      diff_s2_q  <= diff_s2_d;
      de_s2_q    <= de_s2_d;
      hs_s2_q    <= hs_s2_d;
      vs_s2_q    <= vs_s2_d;
      mask_s3_q  <= mask_s3_d;
      de_s3_q    <= de_s3_d;
      hs_s3_q    <= hs_s3_d;
      vs_s3_q    <= vs_s3_d;
      thr_l_q    <= thr_l_d;
      en_l_q     <= en_l_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      fg_count_q <= fg_count_d;
      fg_ovf_q   <= fg_ovf_d;
      fg_valid_q <= fg_valid_d;
    end
  end

  assign out_mask       = mask_s3_q;
  assign out_de         = de_s3_q;
  assign out_hsync      = hs_s3_q;
  assign out_vsync      = vs_s3_q;
  assign fg_count       = fg_count_q;
  assign fg_count_valid = fg_valid_q;
  assign fg_overflow    = fg_ovf_q;

endmodule

// File: tb/tb_foreground_segmentation.sv
// Scoreboard bench for foreground_segmentation: a full-width instance and a
// COUNT_W=4 instance share one directed stimulus stream.
module tb_foreground_segmentation;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] in_image, in_background, threshold;
  logic       in_de, in_hsync, in_vsync, enable;

  logic [7:0]  out_mask, s_out_mask;
  logic        out_de, out_hsync, out_vsync, s_out_de, s_out_hsync, s_out_vsync;
  logic [21:0] fg_count;
  logic [3:0]  s_fg_count;
  logic        fg_count_valid, fg_overflow, s_fg_count_valid, s_fg_overflow;

  foreground_segmentation #(.COUNT_W(22)) dut (
    .clk(clk), .rst(rst), .in_image(in_image), .in_background(in_background),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .threshold(threshold), .enable(enable), .out_mask(out_mask),
    .out_de(out_de), .out_hsync(out_hsync), .out_vsync(out_vsync),
    .fg_count(fg_count), .fg_count_valid(fg_count_valid), .fg_overflow(fg_overflow)
  );

  foreground_segmentation #(.COUNT_W(4)) dut_small (
    .clk(clk), .rst(rst), .in_image(in_image), .in_background(in_background),
    .in_de(in_de), .in_hsync(in_hsync), .in_vsync(in_vsync),
    .threshold(threshold), .enable(enable), .out_mask(s_out_mask),
    .out_de(s_out_de), .out_hsync(s_out_hsync), .out_vsync(s_out_vsync),
    .fg_count(s_fg_count), .fg_count_valid(s_fg_count_valid), .fg_overflow(s_fg_overflow)
  );

  typedef struct {
    logic [21:0] cnt;
    logic        ovf;
    logic [3:0]  s_cnt;
    logic        s_ovf;
  } frame_exp_t;

  logic [7:0] mask_q[$];
  frame_exp_t frame_q[$];
  int         checks = 0;
  int         errors = 0;
  logic [2:0] hist[4];
  logic       prev_valid = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic driveCycle(input logic de, input logic hs, input logic vs,
                            input logic [7:0] img, input logic [7:0] bg);
    @(posedge clk);
    #1;
    in_de = de; in_hsync = hs; in_vsync = vs;
    in_image = img; in_background = bg;
  endtask

  task automatic applyStimulus(input logic [7:0] img, input logic [7:0] bg, input logic [7:0] exp_mask);
    mask_q.push_back(exp_mask);
    driveCycle(1'b1, 1'b0, 1'b0, img, bg);
  endtask

  // Idle cycles carry a large difference so a mask that ignores de shows up.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) driveCycle(1'b0, 1'b0, 1'b0, 8'd255, 8'd0);
  endtask

  task automatic hsyncGap();
    idle(1);
    for (int i = 0; i < 2; i++) driveCycle(1'b0, 1'b1, 1'b0, 8'd255, 8'd0);
    idle(1);
  endtask

  task automatic expectFrame(input logic [21:0] cnt, input logic ovf,
                             input logic [3:0] s_cnt, input logic s_ovf);
    frame_exp_t e;
    e.cnt = cnt; e.ovf = ovf; e.s_cnt = s_cnt; e.s_ovf = s_ovf;
    frame_q.push_back(e);
  endtask

  task automatic frameStart();
    idle(2);
    for (int i = 0; i < 3; i++) driveCycle(1'b0, 1'b0, 1'b1, 8'd255, 8'd0);
    idle(3);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] = 3'b000;
      prev_valid = 1'b0;
      checkOutput("reset_out_mask", {24'd0, out_mask}, 32'd0);
      checkOutput("reset_out_syncs", {29'd0, out_de, out_hsync, out_vsync}, 32'd0);
      checkOutput("reset_fg_count", {10'd0, fg_count}, 32'd0);
      checkOutput("reset_fg_flags", {30'd0, fg_count_valid, fg_overflow}, 32'd0);
    end else begin
      for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {in_de, in_hsync, in_vsync};
      checkOutput("sync_delay", {29'd0, out_de, out_hsync, out_vsync}, {29'd0, hist[3]});
      if (out_de) begin
        if (mask_q.size() == 0) begin
          checkOutput("unexpected_pixel", {24'd0, out_mask}, 32'hFFFF_FFFF);
        end else begin
          checkOutput("mask", {24'd0, out_mask}, {24'd0, mask_q.pop_front()});
        end
      end else begin
        checkOutput("mask_idle", {24'd0, out_mask}, 32'd0);
      end
      checkOutput("valid_match", {31'd0, s_fg_count_valid}, {31'd0, fg_count_valid});
      if (fg_count_valid) begin
        checkOutput("pulse_width", {31'd0, prev_valid}, 32'd0);
        if (frame_q.size() == 0) begin
          checkOutput("unexpected_pulse", {10'd0, fg_count}, 32'hFFFF_FFFF);
        end else begin
          frame_exp_t e;
          e = frame_q.pop_front();
          checkOutput("fg_count", {10'd0, fg_count}, {10'd0, e.cnt});
          checkOutput("fg_overflow", {31'd0, fg_overflow}, {31'd0, e.ovf});
          checkOutput("small_fg_count", {28'd0, s_fg_count}, {28'd0, e.s_cnt});
          checkOutput("small_fg_overflow", {31'd0, s_fg_overflow}, {31'd0, e.s_ovf});
        end
      end
      prev_valid = fg_count_valid;
    end
  end

  initial begin
    rst = 1'b1;
    in_de = 1'b0; in_hsync = 1'b0; in_vsync = 1'b0;
    in_image = 8'd0; in_background = 8'd0;
    threshold = 8'd0; enable = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);
    // Latched enable is 0 after reset, so this pixel must be background.
    applyStimulus(8'd255, 8'd0, 8'd0);
    idle(2);

    threshold = 8'd15; enable = 1'b1;
    frameStart();
    applyStimulus(8'd100, 8'd90, 8'd0);
    applyStimulus(8'd100, 8'd120, 8'd255);
    applyStimulus(8'd100, 8'd100, 8'd0);
    applyStimulus(8'd100, 8'd0, 8'd255);
    hsyncGap();

    threshold = 8'd10;
    expectFrame(22'd2, 1'b0, 4'd2, 1'b0);
    frameStart();
    applyStimulus(8'd50, 8'd60, 8'd0);
    applyStimulus(8'd60, 8'd50, 8'd0);
    applyStimulus(8'd200, 8'd100, 8'd255);

    threshold = 8'd9;
    expectFrame(22'd1, 1'b0, 4'd1, 1'b0);
    frameStart();
    applyStimulus(8'd50, 8'd60, 8'd255);
    applyStimulus(8'd60, 8'd50, 8'd255);

    threshold = 8'd15;
    expectFrame(22'd2, 1'b0, 4'd2, 1'b0);
    frameStart();
    applyStimulus(8'd0, 8'd20, 8'd255);
    threshold = 8'd200;
    applyStimulus(8'd0, 8'd255, 8'd255);
    applyStimulus(8'd0, 8'd100, 8'd255);
    applyStimulus(8'd0, 8'd10, 8'd0);

    expectFrame(22'd3, 1'b0, 4'd3, 1'b0);
    frameStart();
    applyStimulus(8'd0, 8'd255, 8'd255);
    applyStimulus(8'd0, 8'd100, 8'd0);
    applyStimulus(8'd255, 8'd0, 8'd255);

    enable = 1'b0;
    expectFrame(22'd2, 1'b0, 4'd2, 1'b0);
    frameStart();
    applyStimulus(8'd0, 8'd255, 8'd0);
    hsyncGap();
    applyStimulus(8'd255, 8'd0, 8'd0);
    applyStimulus(8'd100, 8'd0, 8'd0);

    enable = 1'b1; threshold = 8'd15;
    expectFrame(22'd0, 1'b0, 4'd0, 1'b0);
    frameStart();
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'd0, 8'd255, 8'd255);
      if (i == 9) hsyncGap();
    end

    expectFrame(22'd20, 1'b0, 4'd15, 1'b1);
    frameStart();
    applyStimulus(8'd255, 8'd0, 8'd255);
    applyStimulus(8'd10, 8'd10, 8'd0);
    applyStimulus(8'd255, 8'd0, 8'd255);
    applyStimulus(8'd255, 8'd0, 8'd255);

    expectFrame(22'd3, 1'b0, 4'd3, 1'b0);
    frameStart();
    applyStimulus(8'd0, 8'd100, 8'd255);
    idle(2);
    // Pixel coincident with the vsync rise closes into the frame ending here.
    mask_q.push_back(8'd255);
    expectFrame(22'd2, 1'b0, 4'd2, 1'b0);
    driveCycle(1'b1, 1'b0, 1'b1, 8'd0, 8'd100);
    driveCycle(1'b0, 1'b0, 1'b1, 8'd255, 8'd0);
    driveCycle(1'b0, 1'b0, 1'b1, 8'd255, 8'd0);
    idle(3);

    applyStimulus(8'd0, 8'd100, 8'd255);
    applyStimulus(8'd0, 8'd100, 8'd255);
    applyStimulus(8'd0, 8'd100, 8'd255);
    @(posedge clk);
    #2;
    checkOutput("pre_reset_mask", {24'd0, out_mask}, 32'd255);
    checkOutput("pre_reset_fg_count", {10'd0, fg_count}, 32'd2);
    rst = 1'b1;
    in_de = 1'b0;
    #1;
    checkOutput("async_reset_mask", {24'd0, out_mask}, 32'd0);
    checkOutput("async_reset_de", {31'd0, out_de}, 32'd0);
    checkOutput("async_reset_fg_count", {10'd0, fg_count}, 32'd0);
    mask_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(2);

    frameStart();
    applyStimulus(8'd0, 8'd100, 8'd255);
    applyStimulus(8'd200, 8'd100, 8'd255);
    applyStimulus(8'd100, 8'd100, 8'd0);
    expectFrame(22'd2, 1'b0, 4'd2, 1'b0);
    frameStart();
    idle(6);

    checkOutput("pixels_outstanding", mask_q.size(), 32'd0);
    checkOutput("frames_outstanding", frame_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
